// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD seven-segment scanner with a frame-aligned double buffer.
// Optional feature: define BCD_SCANNER_LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_display_scanner #(
  parameter int DIGITS      = 4,
  parameter int SLOT_CYCLES = 1000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_enable,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic                pending_q, pending_d, frame_done_q, frame_done_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic [DIGITS-1:0]   lz;
  logic                slot_end, frame_end;
  logic [3:0]          cur_digit;
  logic                cur_dp, cur_lz;
  logic [DIGITS-1:0]   cur_en;
  logic [6:0]          cur_seg;

  always_comb begin
    slot_end     = (slot_q == SLOT_LAST);
    frame_end    = slot_end && (idx_q == IDX_LAST);
    slot_d       = slot_end ? '0 : slot_q + 1'b1;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Display swap uses the pre-edge shadow, so a load on the boundary waits a frame.
    if (frame_end && pending_q) begin
      disp_val_d = shadow_val_q;
      disp_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_mask;
      pending_d    = 1'b1;
    end
    frame_done_d = (slot_d == SLOT_LAST) && (idx_d == IDX_LAST);
  end

`ifdef BCD_SCANNER_LEADING_ZERO_BLANK_EN
  logic zero_run;
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (disp_val_d[4*i +: 4] == 4'd0) && !disp_dp_d[i];
      lz[i]    = zero_run;
    end
  end
`else
  assign lz = '0;
`endif

  // Outputs are decoded from the post-edge position and buffer so enable and pattern never skew.
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    cur_en    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      cur_en[i] = (idx_d == IDX_W'(i));
      if (idx_d == IDX_W'(i)) begin
        cur_digit = disp_val_d[4*i +: 4];
        cur_dp    = disp_dp_d[i];
        cur_lz    = lz[i];
      end
    end
    cur_seg = cur_lz ? 7'b0000000 : seg7(cur_digit);
    if (blank) begin
      cur_seg = 7'b0000000;
      cur_dp  = 1'b0;
      cur_en  = '0;
    end
    seg_d = cur_seg ^ {7{ACTIVE_LOW}};
    dp_d  = cur_dp ^ ACTIVE_LOW;
    en_d  = cur_en ^ {DIGITS{ACTIVE_LOW}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= {7{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
      en_q         <= {DIGITS{ACTIVE_LOW}};
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      en_q         <= en_d;
    end
  end

  assign segments     = seg_q;
  assign dp           = dp_q;
  assign digit_enable = en_q;
  assign pending      = pending_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (DIGITS=4, SLOT_CYCLES=4); an active-high and
// an active-low instance share all inputs.
module tb_bcd_display_scanner;
  localparam int DIGITS = 4;
  localparam int SLOT   = 4;
  localparam int FRAME  = DIGITS * SLOT;
  localparam int NV     = 10;

  localparam logic [6:0] SZ = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1111011, SB = 7'b0000000;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dpm;
    logic [3:0][6:0] seg;
  } vec_t;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] en;
    logic       pend;
    logic       fd;
  } exp_t;

  logic clock = 1'b0;
  logic reset, load, blank;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [6:0]  seg_p, seg_n;
  logic        dp_p, dp_n, pend_p, pend_n, fd_p, fd_n;
  logic [3:0]  en_p, en_n;

  vec_t vec [NV];
  exp_t sbq [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_n, m_shadow, m_disp;
  bit   m_pend;

  always #5 clock = ~clock;

  bcd_display_scanner #(.DIGITS(DIGITS), .SLOT_CYCLES(SLOT), .ACTIVE_LOW(1'b0)) u_dut (
    .clock(clock), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
    .blank(blank), .segments(seg_p), .dp(dp_p), .digit_enable(en_p),
    .pending(pend_p), .frame_done(fd_p)
  );

  bcd_display_scanner #(.DIGITS(DIGITS), .SLOT_CYCLES(SLOT), .ACTIVE_LOW(1'b1)) u_dut_n (
    .clock(clock), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
    .blank(blank), .segments(seg_n), .dp(dp_n), .digit_enable(en_n),
    .pending(pend_n), .frame_done(fd_n)
  );

  task automatic set_vec(input int i, input logic [15:0] v, input logic [3:0] dpm,
                         input logic [6:0] s3, input logic [6:0] s2,
                         input logic [6:0] s1, input logic [6:0] s0);
    vec[i].value = v;
    vec[i].dpm   = dpm;
    vec[i].seg   = {s3, s2, s1, s0};
  endtask

  task automatic fill_vectors();
`ifdef BCD_SCANNER_LEADING_ZERO_BLANK_EN
    set_vec(0, 16'h0000, 4'b0000, SB, SB, SB, SZ);
    set_vec(4, 16'h0070, 4'b0000, SB, SB, S7, SZ);
    set_vec(7, 16'h0900, 4'b0010, SB, S9, SZ, SZ);
    set_vec(8, 16'h0000, 4'b0100, SB, SZ, SZ, SZ);
    set_vec(9, 16'h0001, 4'b0000, SB, SB, SB, S1);
`else
    set_vec(0, 16'h0000, 4'b0000, SZ, SZ, SZ, SZ);
    set_vec(4, 16'h0070, 4'b0000, SZ, SZ, S7, SZ);
    set_vec(7, 16'h0900, 4'b0010, SZ, S9, SZ, SZ);
    set_vec(8, 16'h0000, 4'b0100, SZ, SZ, SZ, SZ);
    set_vec(9, 16'h0001, 4'b0000, SZ, SZ, SZ, S1);
`endif
    set_vec(1, 16'h1234, 4'b0000, S1, S2, S3, S4);
    set_vec(2, 16'h5678, 4'b0000, S5, S6, S7, S8);
    set_vec(3, 16'h9012, 4'b0000, S9, SZ, S1, S2);
    set_vec(5, 16'h0070, 4'b1000, SZ, SZ, S7, SZ);
    set_vec(6, 16'hABCF, 4'b0101, SB, SB, SB, SB);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, m_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n      = 0;
    m_shadow = 0;
    m_disp   = 0;
    m_pend   = 1'b0;
    sbq.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg"},  {25'd0, seg_p}, 32'd0);
    chk({tag, "_dp_en"}, {27'd0, dp_p, en_p}, 32'd0);
    chk({tag, "_pend_fd"}, {30'd0, pend_p, fd_p}, 32'd0);
    chk({tag, "_pins_n"}, {18'd0, seg_n, dp_n, en_n, pend_n, fd_n}, 32'h3FFC);
  endtask

  // Called at a negedge: drive inputs, predict the post-edge outputs, compare after the edge.
  task automatic step(input logic ld, input int vi, input logic bl);
    exp_t       e;
    int         nn, d;
    logic [3:0] one;
    one     = 4'b0001;
    load    = ld;
    value   = vec[vi].value;
    dp_mask = vec[vi].dpm;
    blank   = bl;
    nn = m_n + 1;
    if ((nn % FRAME) == 0 && m_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_shadow = vi;
      m_pend   = 1'b1;
    end
    d = (nn / SLOT) % DIGITS;
    e.seg  = bl ? 7'd0 : vec[m_disp].seg[d];
    e.dp   = bl ? 1'b0 : vec[m_disp].dpm[d];
    e.en   = bl ? 4'd0 : (one << d);
    e.pend = m_pend;
    e.fd   = ((nn % FRAME) == FRAME - 1);
    sbq.push_back(e);
    @(posedge clock);
    #1;
    m_n = nn;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard underflow @cycle %0d: got empty, want one entry", m_n);
    end else begin
      e = sbq.pop_front();
      chk("segments", {25'd0, seg_p}, {25'd0, e.seg});
      chk("dp", {31'd0, dp_p}, {31'd0, e.dp});
      chk("digit_enable", {28'd0, en_p}, {28'd0, e.en});
      chk("pending", {31'd0, pend_p}, {31'd0, e.pend});
      chk("frame_done", {31'd0, fd_p}, {31'd0, e.fd});
      chk("pins_active_low", {18'd0, seg_n, dp_n, en_n, pend_n, fd_n},
          {18'd0, ~e.seg, ~e.dp, ~e.en, e.pend, e.fd});
    end
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic run(input int k);
    repeat (k) step(1'b0, 0, 1'b0);
  endtask

  task automatic align(input int modv, input int r);
    while ((m_n % modv) != r) step(1'b0, 0, 1'b0);
  endtask

  initial begin
    fill_vectors();
    reset = 1'b0; load = 1'b0; blank = 1'b0; value = '0; dp_mask = '0;
    m_n = 0;
    #3 reset = 1'b1;
    #1 chk_reset("por");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();

    // 0x1234 shown after the next boundary; frame_done every 16 cycles.
    run(2);
    step(1'b1, 1, 1'b0);
    run(40);

    // Two loads inside one frame: only the second is ever displayed.
    align(FRAME, 1);
    step(1'b1, 2, 1'b0);
    run(3);
    step(1'b1, 3, 1'b0);
    run(40);

    // Pending load, then a second load sampled on the boundary edge itself.
    align(FRAME, 2);
    step(1'b1, 4, 1'b0);
    while (((m_n + 1) % FRAME) != 0) step(1'b0, 0, 1'b0);
    step(1'b1, 5, 1'b0);
    run(40);

    // Decode table, dp handling and leading-zero cases at varying load phases.
    for (int i = 0; i < NV; i++) begin
      step(1'b1, i, 1'b0);
      run(34 + i);
    end

    // Blank asserted mid-slot; counters keep running underneath.
    align(SLOT, 1);
    repeat (5) step(1'b0, 0, 1'b1);
    run(20);

    // Asynchronous reset mid-frame with a pending load: shadow is discarded.
    step(1'b1, 2, 1'b0);
    run(3);
    #2 reset = 1'b1;
    #1 chk_reset("mid");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed driver for a DIGITS-wide common-bus seven-segment display. It holds a packed BCD value with per-digit decimal points and scans one digit per slot, driving the shared segment bus and a one-hot digit enable. New values are double-buffered and applied only at frame boundaries, so the display never shows a mix of old and new digits. The block sits between the numeric datapath (counters, BCD converters) and the board display pins, and replaces per-digit static decoders.

## Interface
- DIGITS, 4: number of display digits, 1..8.
- SLOT_CYCLES, 1000: clock cycles each digit is enabled per scan, ≥2.
- ACTIVE_LOW, 0: 1 inverts `segments`, `dp` and `digit_enable` at the pins.

- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures `value`/`dp_mask` into the shadow register.
- value  in  4*DIGITS  packed BCD; digit i = value[4i+3:4i], digit 0 least significant.
- dp_mask  in  DIGITS  decimal point per digit.
- blank  in  1  synchronous display blank; scanning continues.
- segments  out  7  {a,b,c,d,e,f,g}, bit 6 = a, logical 1 = lit.
- dp  out  1  decimal point of the enabled digit.
- digit_enable  out  DIGITS  one-hot enable of the current digit.
- pending  out  1  shadow holds a value not yet displayed.
- frame_done  out  1  one-cycle pulse on the last cycle of digit DIGITS-1.

## Operation
- Registers:
  - slot counter, 0..SLOT_CYCLES-1.
  - digit index, 0..DIGITS-1.
  - shadow value/dp.
  - display value/dp.
  - pending flag.
  - all outputs.
- Slot counter increments every cycle. At SLOT_CYCLES-1 it wraps to 0 and the index advances. The index wraps from DIGITS-1 to 0.
- Frame boundary is the edge where the index wraps DIGITS-1→0. `frame_done` is high during the cycle before that edge.
- `load` copies the inputs to the shadow and sets `pending`.
- At a frame boundary with `pending`=1, the display register takes the shadow contents and `pending` clears.
- Load while pending: the shadow is overwritten and `pending` stays 1 (last write wins).
- Load on a frame-boundary edge: the display takes the pre-edge shadow contents. The new value stays in the shadow with `pending`=1 until the next boundary.
- Decode, per digit:
  - 0 → 1111110
  - 1 → 0110000
  - 2 → 1101101
  - 3 → 1111001
  - 4 → 0110011
  - 5 → 1011011
  - 6 → 1011111
  - 7 → 1110000
  - 8 → 1111111
  - 9 → 1111011
  - codes 10–15 → 0000000
- `blank`=1: `segments`, `dp` and `digit_enable` are logically 0 from the next edge. Counters and buffering are unaffected.
- ACTIVE_LOW applies after all of the above logic.

## Timing
- Reset (asynchronous):
  - counters 0, shadow 0, display 0, `pending` 0, `frame_done` 0.
  - `segments`, `dp` and `digit_enable` all logically 0, i.e. all-ones at the pins when ACTIVE_LOW=1.
- First edge after reset release: outputs show digit 0 of the display register.
- Outputs are registered and all change on the same edge. `digit_enable`, `segments` and `dp` always describe the same digit; there is no cycle with a stale pattern on a new enable.
- Latency:
  - `load` → `pending`=1 after 1 edge.
  - Shadow → display at the next frame boundary, worst case DIGITS*SLOT_CYCLES cycles.
- Each digit is enabled for exactly SLOT_CYCLES cycles per frame.
- Reset mid-frame aborts the scan and discards the shadow contents.

## Configuration
- `BCD_SCANNER_LEADING_ZERO_BLANK_EN` defined:
  - Digit i>0 is blanked (segments 0000000) when it and every more-significant digit are 0.
  - A digit whose dp bit is set is never blanked and ends blanking for all lower digits.
  - Digit 0 is never blanked.
- Macro undefined: every digit is decoded as-is and zeros are displayed.

## Test plan
- DIGITS=4, SLOT_CYCLES=4, after reset:
  - Load 0x1234 → after the next boundary, the enable sequence 0001, 0010, 0100, 1000 shows 4, 3, 2, 1 (0110011, 1111001, 1101101, 0110000), each held for 4 cycles.
  - `frame_done` pulses every 16 cycles.
- Load 0x5678 then 0x9012 within one frame → `pending`=1 throughout; only 9012 is ever displayed; `pending` clears at the boundary.
- Load asserted on the boundary edge → the old shadow is displayed for one frame, then the new value; `pending` stays 1 across that frame.
- Macro defined:
  - Load 0x0070, dp_mask 0000 → digits 3 and 2 blank, digit 1 shows 1110000, digit 0 shows 1111110.
  - With dp_mask 1000, digit 3 shows 1111110 and dp=1.
- `blank`=1 mid-slot → the next edge drives all outputs to 0; after release the scan resumes at the position the free-running counter has reached.
- Assert `reset` mid-frame with ACTIVE_LOW=1 → outputs go all-ones immediately without a clock edge; `pending`=0.
